// File: rtl/hack_mem_arbiter.sv
// rtl/hack_mem_arbiter.sv - CPU/video arbiter for the shared Hack data-memory port
// CPU wins ties unless video has waited VID_MAX_WAIT cycles; one memory access per cycle.
module hack_mem_arbiter #(
  parameter int          VID_MAX_WAIT = 4,
  parameter int          WAIT_W       = 3,
  parameter logic [0:14] SCREEN_BASE  = 15'h4000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [0:14] cpu_addr,
  input  logic [0:15] cpu_wdata,
  output logic        cpu_ack,
  output logic [0:15] cpu_rdata,
  input  logic        vid_req,
  input  logic [0:12] vid_addr,
  output logic        vid_ack,
  output logic [0:15] vid_rdata,
  output logic        mem_load,
  output logic [0:14] mem_addr,
  output logic [0:15] mem_in,
  input  logic [0:15] mem_out
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, VID_ACC} state_t;

  localparam logic [0:WAIT_W-1] WAIT_LIMIT = WAIT_W'(VID_MAX_WAIT);
  localparam logic [0:WAIT_W-1] WAIT_SAT   = '1;

  state_t            state;
  state_t            state_nxt;
  logic [0:WAIT_W-1] wait_cnt;
  logic              cpu_elig;
  logic              vid_elig;
  logic              vid_starved;

  // A requester being served or being acked this cycle cannot win the next slot.
  assign cpu_elig    = cpu_req && !cpu_ack && (state != CPU_ACC);
  assign vid_elig    = vid_req && !vid_ack && (state != VID_ACC);
  assign vid_starved = (wait_cnt >= WAIT_LIMIT);

  always_comb begin
    state_nxt = IDLE;
    if (cpu_elig && vid_elig) begin
      state_nxt = vid_starved ? VID_ACC : CPU_ACC;
    end else if (cpu_elig) begin
      state_nxt = CPU_ACC;
    end else if (vid_elig) begin
      state_nxt = VID_ACC;
    end
  end

  // Reset gates the write strobe so a write caught mid-access never lands.
  always_comb begin
    mem_addr = '0;
    mem_in   = '0;
    mem_load = 1'b0;
    case (state)
      CPU_ACC: begin
        mem_addr = cpu_addr;
        mem_in   = cpu_wdata;
        mem_load = cpu_we && !reset;
      end
      VID_ACC: begin
        mem_addr = SCREEN_BASE + {2'b00, vid_addr};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
      wait_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      cpu_ack <= (state == CPU_ACC);
      vid_ack <= (state == VID_ACC);
      if (state == CPU_ACC && !cpu_we) begin
        cpu_rdata <= mem_out;
      end
      if (state == VID_ACC) begin
        vid_rdata <= mem_out;
      end
      // VID_ACC never follows itself, so any grant to video is an entry.
      if (state_nxt == VID_ACC) begin
        wait_cnt <= '0;
      end else if (vid_req && wait_cnt != WAIT_SAT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule
